morse_keyer: RTL and testbench

//   Parametrised Morse element sequencer that drives one LED with standard ITU timing.

---
 rtl/morse_keyer.sv | 177 +++++++++++++++++
 tb/tb_morse_keyer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
//   Keys one Morse letter per start handshake onto a single LED using ITU
//   element timing. The dot is 1 unit, the dash is 3 units, the gap between
//   elements is 1 unit, the trailing letter gap is 3 units and the word space
//   is 7 units. One unit is UNIT_CYCLES >> speed_sel clock cycles, and is at
//   least 1 cycle. When repeat_en is high at the end of the trailing gap, the
//   latched letter is keyed again.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, accepted only while ready=1
//   sym_bits   in   element k = sym_bits[k], LSB first; 0=dot, 1=dash
//   sym_len    in   element count, clamped to MAX_SYMS; 0 = word space
//   speed_sel  in   unit divider exponent
//   repeat_en  in   loop the latched letter, sampled at the end of each gap
//   ready      out  idle, so start is accepted this cycle
//   busy       out  a letter is in progress
//   done       out  1-cycle pulse in the first cycle after a letter's gap
//   LED        out  keyed output, 1 = mark
// -----------------------------------------------------------------------------
module morse_keyer #(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int MAX_SYMS    = 6,
  parameter int CNT_W       = 32,
  parameter int LEN_W       = $clog2(MAX_SYMS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MAX_SYMS-1:0] sym_bits,
  input  logic [LEN_W-1:0]    sym_len,
  input  logic [1:0]          speed_sel,
  input  logic                repeat_en,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                LED
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MARK = 3'd1,
    EGAP = 3'd2,
    LGAP = 3'd3,
    WGAP = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0]    unit_reg, unit_next;
  logic [LEN_W-1:0]    elem_idx_reg, elem_idx_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [MAX_SYMS-1:0] bits_reg, bits_next;
  logic                led_reg, led_next;
  logic                done_reg, done_next;

  // Unit length selected at accept time. It is never allowed to reach zero.
  logic [CNT_W-1:0]    unit_shift;
  logic [CNT_W-1:0]    unit_sel;
  logic [LEN_W-1:0]    len_clamped;

  assign unit_shift  = CNT_W'(UNIT_CYCLES) >> speed_sel;
  assign unit_sel    = (unit_shift == '0) ? CNT_W'(1) : unit_shift;
  assign len_clamped = (sym_len > LEN_W'(MAX_SYMS)) ? LEN_W'(MAX_SYMS) : sym_len;

  // Current element and the duration of the current phase.
  logic [MAX_SYMS-1:0] bits_shifted;
  logic                cur_dash;
  logic [CNT_W-1:0]    unit_x3;
  logic [CNT_W-1:0]    unit_x7;
  logic [CNT_W-1:0]    phase_dur;
  logic                phase_end;
  logic                more_elems;

  assign bits_shifted = bits_reg >> elem_idx_reg;
  assign cur_dash     = bits_shifted[0];
  assign unit_x3      = (unit_reg << 1) + unit_reg;
  assign unit_x7      = (unit_reg << 3) - unit_reg;
  assign phase_end    = (cnt_reg == phase_dur - CNT_W'(1));
  assign more_elems   = ((elem_idx_reg + LEN_W'(1)) < len_reg);

  always_comb begin
    phase_dur = unit_reg;
    case (state_reg)
      MARK:    phase_dur = cur_dash ? unit_x3 : unit_reg;
      EGAP:    phase_dur = unit_reg;
      LGAP:    phase_dur = unit_x3;
      WGAP:    phase_dur = unit_x7;
      default: phase_dur = unit_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      unit_reg     <= '0;
      elem_idx_reg <= '0;
      len_reg      <= '0;
      bits_reg     <= '0;
      led_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      unit_reg     <= unit_next;
      elem_idx_reg <= elem_idx_next;
      len_reg      <= len_next;
      bits_reg     <= bits_next;
      led_reg      <= led_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CNT_W'(1);
    unit_next     = unit_reg;
    elem_idx_next = elem_idx_reg;
    len_next      = len_reg;
    bits_next     = bits_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          bits_next     = sym_bits;
          len_next      = len_clamped;
          unit_next     = unit_sel;
          elem_idx_next = '0;
          state_next    = (len_clamped != '0) ? MARK : WGAP;
        end
      end
      MARK: begin
        if (phase_end) begin
          cnt_next   = '0;
          state_next = more_elems ? EGAP : LGAP;
        end
      end
      EGAP: begin
        if (phase_end) begin
          cnt_next      = '0;
          elem_idx_next = elem_idx_reg + LEN_W'(1);
          state_next    = MARK;
        end
      end
      LGAP, WGAP: begin
        if (phase_end) begin
          cnt_next      = '0;
          done_next     = 1'b1;
          elem_idx_next = '0;
          if (repeat_en) begin
            state_next = (len_reg != '0) ? MARK : WGAP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // The LED register follows the next state, so it is high for exactly the MARK cycles.
    led_next = (state_next == MARK);
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign LED   = led_reg;

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
//   Directed self-checking bench for morse_keyer with UNIT_CYCLES=4.
//   Inputs change on the falling edge and outputs are sampled on the falling
//   edge. Cycle n after accept is the n-th falling edge after the accept edge.
// -----------------------------------------------------------------------------
module tb_morse_keyer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] sym_bits = '0;
  logic [2:0] sym_len = '0;
  logic [1:0] speed_sel = '0;
  logic       repeat_en = 1'b0;
  logic       ready, busy, done, LED;

  int checks = 0;
  int failures = 0;

  morse_keyer #(
    .UNIT_CYCLES(4),
    .MAX_SYMS(6),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .sym_bits(sym_bits),
    .sym_len(sym_len),
    .speed_sel(speed_sel),
    .repeat_en(repeat_en),
    .ready(ready),
    .busy(busy),
    .done(done),
    .LED(LED)
  );

  always #5 clk = ~clk;

  // Pulses start for one edge. On return we are at the falling edge of cycle 1 after accept.
  task automatic do_start(input logic [5:0] bits, input logic [2:0] len, input logic [1:0] spd);
    sym_bits  = bits;
    sym_len   = len;
    speed_sel = spd;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({LED, busy, ready, done} !== 4'b0010) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: LED/busy/ready/done=%b required 0010", i, {LED, busy, ready, done});
      end
    end
    $display("test_reset: 20 idle cycles checked");
  endtask

  task automatic test_letter_a;
    logic exp_led;
    do_start(6'b000010, 3'd2, 2'd0);
    for (int i = 1; i <= 36; i++) begin
      exp_led = (i <= 4) || (i >= 9 && i <= 20);
      checks++;
      if (LED !== exp_led) begin
        failures++;
        $display("FAIL a_led cycle %0d: got %b required %b", i, LED, exp_led);
      end
      checks++;
      if (done !== (i == 33)) begin
        failures++;
        $display("FAIL a_done cycle %0d: got %b required %b", i, done, (i == 33));
      end
      checks++;
      if (ready !== (i >= 33)) begin
        failures++;
        $display("FAIL a_ready cycle %0d: got %b required %b", i, ready, (i >= 33));
      end
      @(negedge clk);
    end
    $display("test_letter_a: keyed A at unit 4");
  endtask

  task automatic test_word_space;
    do_start(6'b101010, 3'd0, 2'd0);
    for (int i = 1; i <= 32; i++) begin
      checks++;
      if (LED !== 1'b0) begin
        failures++;
        $display("FAIL ws_led cycle %0d: got %b required 0", i, LED);
      end
      checks++;
      if (done !== (i == 29)) begin
        failures++;
        $display("FAIL ws_done cycle %0d: got %b required %b", i, done, (i == 29));
      end
      checks++;
      if (busy !== (i < 29)) begin
        failures++;
        $display("FAIL ws_busy cycle %0d: got %b required %b", i, busy, (i < 29));
      end
      @(negedge clk);
    end
    $display("test_word_space: 7-unit space");
  endtask

  task automatic test_fast_e;
    do_start(6'b000000, 3'd1, 2'd2);
    for (int i = 1; i <= 15; i++) begin
      // Second start while busy, with different fields; it must be dropped.
      if (i == 2) begin
        sym_bits = 6'b111111;
        sym_len  = 3'd6;
        start    = 1'b1;
      end
      if (i == 3) start = 1'b0;
      checks++;
      if (LED !== (i == 1)) begin
        failures++;
        $display("FAIL e_led cycle %0d: got %b required %b", i, LED, (i == 1));
      end
      checks++;
      if (done !== (i == 5)) begin
        failures++;
        $display("FAIL e_done cycle %0d: got %b required %b", i, done, (i == 5));
      end
      checks++;
      if (busy !== (i < 5)) begin
        failures++;
        $display("FAIL e_busy cycle %0d: got %b required %b", i, busy, (i < 5));
      end
      @(negedge clk);
    end
    $display("test_fast_e: E at unit 1, busy start ignored");
  endtask

  task automatic test_repeat_t;
    logic exp_led;
    logic exp_done;
    repeat_en = 1'b1;
    do_start(6'b000001, 3'd1, 2'd0);
    for (int i = 1; i <= 80; i++) begin
      if (i == 50) repeat_en = 1'b0;
      exp_led  = (i <= 72) && (((i - 1) % 24) < 12);
      exp_done = (i == 25) || (i == 49) || (i == 73);
      checks++;
      if (LED !== exp_led) begin
        failures++;
        $display("FAIL t_led cycle %0d: got %b required %b", i, LED, exp_led);
      end
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL t_done cycle %0d: got %b required %b", i, done, exp_done);
      end
      checks++;
      if (ready !== (i >= 73)) begin
        failures++;
        $display("FAIL t_ready cycle %0d: got %b required %b", i, ready, (i >= 73));
      end
      @(negedge clk);
    end
    $display("test_repeat_t: T keyed 3 times in beacon mode");
  endtask

  task automatic test_reset_mid_o;
    logic exp_led;
    do_start(6'b000111, 3'd3, 2'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (LED !== 1'b1) begin
      failures++;
      $display("FAIL o_pre_reset_led: got %b required 1", LED);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({LED, ready, busy, done} !== 4'b0100) begin
      failures++;
      $display("FAIL o_async_reset LED/ready/busy/done: got %b required 0100", {LED, ready, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({LED, done} !== 2'b00) begin
        failures++;
        $display("FAIL o_in_reset cycle %0d LED/done: got %b required 00", i, {LED, done});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({LED, ready, done} !== 3'b010) begin
      failures++;
      $display("FAIL o_after_release LED/ready/done: got %b required 010", {LED, ready, done});
    end
    do_start(6'b000111, 3'd3, 2'd0);
    for (int i = 1; i <= 60; i++) begin
      exp_led = (i <= 12) || (i >= 17 && i <= 28) || (i >= 33 && i <= 44);
      checks++;
      if (LED !== exp_led) begin
        failures++;
        $display("FAIL o_led cycle %0d: got %b required %b", i, LED, exp_led);
      end
      checks++;
      if (done !== (i == 57)) begin
        failures++;
        $display("FAIL o_done cycle %0d: got %b required %b", i, done, (i == 57));
      end
      @(negedge clk);
    end
    $display("test_reset_mid_o: abort then full O");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_letter_a();
    test_word_space();
    test_fast_e();
    test_repeat_t();
    test_reset_mid_o();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
